// File: rtl/pipe_arbiter.sv
// Two-requester round-robin front end for a shared fixed-latency datapath.
// It tags each accepted operand set so the result goes back to the requester that sent it.
module pipe_arbiter #(
    parameter int unsigned W       = 10,
    parameter int unsigned LATENCY = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [W-1:0] req0_c,
    input  logic [W-1:0] req0_d,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [W-1:0] req1_c,
    input  logic [W-1:0] req1_d,
    output logic         req1_ready,
    output logic [W-1:0] pipe_a,
    output logic [W-1:0] pipe_b,
    output logic [W-1:0] pipe_c,
    output logic [W-1:0] pipe_d,
    input  logic [W-1:0] pipe_f,
    output logic         rsp0_valid,
    output logic [W-1:0] rsp0_f,
    output logic         rsp1_valid,
    output logic [W-1:0] rsp1_f,
    input  logic         drain,
    output logic [3:0]   inflight,
    output logic         idle
);

    // One extra tag stage covers the operand register in front of the datapath
    localparam int unsigned DEPTH = LATENCY + 1;

    logic             last_grant;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             resp;
    logic [DEPTH-1:0] tag_v;
    logic [DEPTH-1:0] tag_id;
    logic [3:0]       inflight_nxt;

    // Round-robin grant: on contention the requester not granted last wins
    always_comb begin
        grant0 = req0_valid & ~drain & (~req1_valid | last_grant);
        grant1 = req1_valid & ~drain & (~req0_valid | ~last_grant);
        accept = grant0 | grant1;
        resp   = tag_v[DEPTH-1];
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        inflight_nxt = inflight;
        if (accept && !resp) begin
            inflight_nxt = inflight + 4'd1;
        end else if (!accept && resp) begin
            inflight_nxt = inflight - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            pipe_a     <= '0;
            pipe_b     <= '0;
            pipe_c     <= '0;
            pipe_d     <= '0;
            tag_v      <= '0;
            tag_id     <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_f     <= '0;
            rsp1_f     <= '0;
            inflight   <= '0;
            idle       <= 1'b1;
        end else begin
            if (accept) begin
                last_grant <= grant1;
                pipe_a     <= grant0 ? req0_a : req1_a;
                pipe_b     <= grant0 ? req0_b : req1_b;
                pipe_c     <= grant0 ? req0_c : req1_c;
                pipe_d     <= grant0 ? req0_d : req1_d;
            end
            tag_v      <= {tag_v[DEPTH-2:0], accept};
            tag_id     <= {tag_id[DEPTH-2:0], grant1};
            rsp0_valid <= resp & ~tag_id[DEPTH-1];
            rsp1_valid <= resp & tag_id[DEPTH-1];
            if (resp && !tag_id[DEPTH-1]) begin
                rsp0_f <= pipe_f;
            end
            if (resp && tag_id[DEPTH-1]) begin
                rsp1_f <= pipe_f;
            end
            inflight <= inflight_nxt;
            idle     <= (inflight_nxt == 4'd0);
        end
    end

endmodule
